// File: rtl/crop_filter_pkg.sv
// rtl/crop_filter_pkg.sv - shared types, default geometry and helpers for the crop stage
package crop_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_PIXEL_BIT_WIDTH = 10;
    localparam int DEF_IN_ROWS         = 20;
    localparam int DEF_IN_COLS         = 20;
    localparam int DEF_OUT_ROWS        = 10;
    localparam int DEF_OUT_COLS        = 10;

    localparam int ROW_W        = $clog2(DEF_IN_ROWS);
    localparam int COL_W        = $clog2(DEF_IN_COLS);
    localparam int FRAME_PIXELS = DEF_IN_ROWS * DEF_IN_COLS;

    // Keeps the window inside the frame when the requested origin is too far out.
    function automatic int clamp_off(input int off, input int lim);
        return (off > lim) ? lim : off;
    endfunction

endpackage

// File: rtl/crop_filter_if.sv
// rtl/crop_filter_if.sv - pixel stream bundle with producer/consumer views
interface crop_filter_if #(
    parameter int W = 10
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/crop_filter_axis_out_reg.sv
// rtl/crop_filter_axis_out_reg.sv - one-entry stream output register
module axis_out_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         in_ready,
    crop_filter_if.master m_axis
);
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = load_last;
            data_d  = load_data;
        end else if (m_axis.tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign in_ready      = !valid_q || m_axis.tready;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tdata  = data_q;

endmodule

// File: rtl/crop_filter.sv
// rtl/crop_filter.sv - crops a raster frame to a window and tracks the window maximum
module crop_filter
    import crop_filter_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
    parameter int IN_ROWS         = DEF_IN_ROWS,
    parameter int IN_COLS         = DEF_IN_COLS,
    parameter int OUT_ROWS        = DEF_OUT_ROWS,
    parameter int OUT_COLS        = DEF_OUT_COLS
) (
    input  logic                         clk,
    input  logic                         s_axis_resetn,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_ready,
    output logic                         ap_idle,
    input  logic [$clog2(IN_ROWS)-1:0]   crop_row0,
    input  logic [$clog2(IN_COLS)-1:0]   crop_col0,
    crop_filter_if.slave                 s_axis,
    crop_filter_if.master                m_axis,
    output logic [PIXEL_BIT_WIDTH-1:0]   norm_denominator,
    output logic                         frame_err
);
    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);

    state_t                     state_q, state_d;
    logic [RW-1:0]              row_q, row_d, row0_q, row0_d;
    logic [CW-1:0]              col_q, col_d, col0_q, col0_d;
    logic [PIXEL_BIT_WIDTH-1:0] max_q, max_d;
    logic                       err_q, err_d;

    logic          out_ready, accept, final_beat, in_win, win_last, load;
    logic [RW:0]   row_x, row_lo, row_hi, row_end;
    logic [CW:0]   col_x, col_lo, col_hi, col_end;

    // Window bounds are compared one bit wider so row0+OUT_ROWS cannot wrap.
    always_comb begin
        row_x   = {1'b0, row_q};
        col_x   = {1'b0, col_q};
        row_lo  = {1'b0, row0_q};
        col_lo  = {1'b0, col0_q};
        row_hi  = row_lo + (RW+1)'(OUT_ROWS);
        col_hi  = col_lo + (CW+1)'(OUT_COLS);
        row_end = row_hi - (RW+1)'(1);
        col_end = col_hi - (CW+1)'(1);
        in_win   = (row_x >= row_lo) && (row_x < row_hi) && (col_x >= col_lo) && (col_x < col_hi);
        win_last = (row_x == row_end) && (col_x == col_end);
        final_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);
        accept   = s_axis.tvalid && s_axis.tready;
        load     = accept && in_win;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        row0_d  = row0_q;
        col0_d  = col0_q;
        max_d   = max_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = RUN;
                    row0_d  = RW'(clamp_off(int'(crop_row0), IN_ROWS - OUT_ROWS));
                    col0_d  = CW'(clamp_off(int'(crop_col0), IN_COLS - OUT_COLS));
                    row_d   = '0;
                    col_d   = '0;
                    max_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (load && (s_axis.tdata > max_q)) max_d = s_axis.tdata;
                    if (s_axis.tlast != final_beat) err_d = 1'b1;
                    if (final_beat) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_axis.tvalid || m_axis.tready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            row0_q  <= '0;
            col0_q  <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            row0_q  <= row0_d;
            col0_q  <= col0_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    axis_out_reg #(
        .W(PIXEL_BIT_WIDTH)
    ) u_out (
        .clk       (clk),
        .rst_n     (s_axis_resetn),
        .load      (load),
        .load_data (s_axis.tdata),
        .load_last (win_last),
        .in_ready  (out_ready),
        .m_axis    (m_axis)
    );

    assign s_axis.tready    = (state_q == RUN) && out_ready;
    assign ap_done          = (state_q == DONE);
    assign ap_ready         = (state_q == IDLE);
    assign ap_idle          = (state_q == IDLE);
    assign norm_denominator = (max_q == '0) ? PIXEL_BIT_WIDTH'(1) : max_q;
    assign frame_err        = err_q;

endmodule

// File: tb/tb_crop_filter.sv
// tb/tb_crop_filter.sv - directed bench for crop_filter
module tb_crop_filter;

    logic       clk = 1'b0;
    logic       s_axis_resetn = 1'b0;
    logic       ap_start = 1'b0;
    logic       ap_done, ap_ready, ap_idle;
    logic [4:0] crop_row0 = '0;
    logic [4:0] crop_col0 = '0;
    logic [9:0] norm_denominator;
    logic       frame_err;

    crop_filter_if #(.W(10)) s_if ();
    crop_filter_if #(.W(10)) m_if ();

    crop_filter dut (
        .clk              (clk),
        .s_axis_resetn    (s_axis_resetn),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .crop_row0        (crop_row0),
        .crop_col0        (crop_col0),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .norm_denominator (norm_denominator),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int         passed = 0;
    int         total  = 0;
    logic [9:0] outs[$];
    logic       lasts[$];
    int         done_cnt;
    int         tready_err;
    logic       err_after_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input int beat, input bit zero, input int bad_beat);
        s_if.tvalid = (beat < 400);
        s_if.tdata  = zero ? 10'd0 : 10'(beat);
        s_if.tlast  = (beat == 399) || (beat == bad_beat);
    endtask

    task automatic run_frame(input int r0, input int c0, input bit tog, input bit zero,
                             input int bad_beat, input int abort_beat);
        int beat, cyc, post;
        bit s_hs;
        beat = 0; cyc = 0; post = 0;
        done_cnt = 0; tready_err = 0;
        outs.delete(); lasts.delete();
        @(posedge clk); #1;
        crop_row0 = 5'(r0);
        crop_col0 = 5'(c0);
        ap_start  = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        err_after_start = frame_err;
        m_if.tready = 1'b1;
        drive_beat(beat, zero, bad_beat);
        while (cyc < 4000 && post < 4) begin
            @(negedge clk);
            if (ap_done) done_cnt++;
            if (m_if.tvalid && m_if.tready) begin
                outs.push_back(m_if.tdata);
                lasts.push_back(m_if.tlast);
            end
            if (m_if.tvalid && !m_if.tready && s_if.tready) tready_err++;
            s_hs = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            if (s_hs) beat++;
            if (abort_beat >= 0 && beat == abort_beat) return;
            drive_beat(beat, zero, bad_beat);
            if (tog) m_if.tready = !m_if.tready;
            if (done_cnt > 0) post++;
            cyc++;
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int r0, input int c0, input bit zero,
                               input bit exp_err);
        int er, ec, mism, nlast, exp_v, exp_max;
        logic [9:0] first_v, last_v;
        er = (r0 > 10) ? 10 : r0;
        ec = (c0 > 10) ? 10 : c0;
        mism = 0; nlast = 0;
        for (int i = 0; i < outs.size(); i++) begin
            exp_v = zero ? 0 : (er + i / 10) * 20 + ec + i % 10;
            if (i >= 100 || outs[i] !== 10'(exp_v)) mism++;
            if (lasts[i]) nlast++;
        end
        first_v = (outs.size() > 0) ? outs[0] : 10'h3ff;
        last_v  = (outs.size() > 0) ? outs[outs.size()-1] : 10'h3ff;
        exp_max = zero ? 1 : (er + 9) * 20 + ec + 9;
        chk({tag, "_beats"}, outs.size(), 100);
        chk({tag, "_first"}, first_v, zero ? 0 : er * 20 + ec);
        chk({tag, "_lastpix"}, last_v, 32'(exp_max == 1 && zero ? 0 : exp_max));
        chk({tag, "_seq_mism"}, mism, 0);
        chk({tag, "_tlast_cnt"}, nlast, 1);
        chk({tag, "_tlast_pos"}, (lasts.size() > 0) ? lasts[lasts.size()-1] : 1'b0, 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_norm"}, norm_denominator, exp_max);
        chk({tag, "_frame_err"}, frame_err, exp_err);
        chk({tag, "_idle"}, ap_idle, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ap_done"}, ap_done, 0);
        chk({tag, "_ap_ready"}, ap_ready, 1);
        chk({tag, "_ap_idle"}, ap_idle, 1);
        chk({tag, "_s_tready"}, s_if.tready, 0);
        chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
        chk({tag, "_m_tdata"}, m_if.tdata, 0);
        chk({tag, "_m_tlast"}, m_if.tlast, 0);
        chk({tag, "_norm"}, norm_denominator, 1);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        int rst_done;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        s_axis_resetn = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        run_frame(5, 5, 1'b0, 1'b0, -1, -1);
        check_frame("ramp55", 5, 5, 1'b0, 1'b0);

        run_frame(15, 17, 1'b0, 1'b0, -1, -1);
        check_frame("clamp", 15, 17, 1'b0, 1'b0);

        run_frame(5, 5, 1'b1, 1'b0, -1, -1);
        check_frame("toggle", 5, 5, 1'b0, 1'b0);
        chk("toggle_tready_rule", tready_err, 0);

        run_frame(5, 5, 1'b0, 1'b1, -1, -1);
        check_frame("zero", 5, 5, 1'b1, 1'b0);

        run_frame(5, 5, 1'b0, 1'b0, 57, -1);
        check_frame("badlast", 5, 5, 1'b0, 1'b1);

        run_frame(5, 5, 1'b0, 1'b0, -1, -1);
        chk("err_cleared_on_start", err_after_start, 0);
        check_frame("after_err", 5, 5, 1'b0, 1'b0);

        run_frame(5, 5, 1'b0, 1'b0, -1, 150);
        chk("abort_busy", ap_idle, 0);
        s_if.tvalid = 1'b0;
        s_axis_resetn = 1'b0;
        #1;
        check_reset_vals("abort");
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (ap_done) rst_done++;
        end
        chk("abort_no_done", rst_done, 0);
        @(posedge clk); #1;
        s_axis_resetn = 1'b1;

        run_frame(5, 5, 1'b0, 1'b0, -1, -1);
        check_frame("recover", 5, 5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
